// File: rtl/ulpi_reg_write_if.sv
// ulpi_reg_write_if: request/response and ULPI control signals of the register-write
// initiator. The slave modport is the initiator; the master modport is the environment
// (configuration sequencer plus PHY control pins). The tri-state ulpi_data bus is a
// separate top-level inout on the initiator.
interface ulpi_reg_write_if;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       en;
    logic       busy;
    logic       done;
    logic       error;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic       ulpi_stp;

    modport master (
        output addr, wdata, en, ulpi_dir, ulpi_nxt,
        input  busy, done, error, ulpi_stp
    );

    modport slave (
        input  addr, wdata, en, ulpi_dir, ulpi_nxt,
        output busy, done, error, ulpi_stp
    );
endinterface

// File: rtl/ulpi_reg_write.sv
// ulpi_reg_write: link-side ULPI register write (TXCMD, data byte, STP) with automatic
// retry when the PHY turns the bus around, and an NXT stall timeout.
// Optional macro ULPI_EXT_ADDR_EN adds the extended-address form (TXCMD 8'hAF followed
// by a full 8-bit address byte) for addresses above 8'h3F.
module ulpi_reg_write #(
    parameter int unsigned NXT_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    ulpi_reg_write_if.slave  bus,
    inout  wire  [7:0]       ulpi_data
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(NXT_TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TXCMD = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STP   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
`ifdef ULPI_EXT_ADDR_EN
    localparam logic [2:0] S_EXT   = 3'd5;
`endif

    logic [2:0]       state_q, state_d;
    logic [7:0]       addr_q,  addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       data_q,  data_d;
    logic             oe_q,    oe_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             error_q, error_d;
    logic             stp_q,   stp_d;

    logic [7:0]       cmd_new_c;
    logic [7:0]       cmd_lat_c;
    logic             is_tx_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Command byte for a fresh request and for a retry from the latched address
`ifdef ULPI_EXT_ADDR_EN
    assign cmd_new_c = (bus.addr > 8'h3F) ? 8'hAF : {2'b10, bus.addr[5:0]};
    assign cmd_lat_c = (addr_q   > 8'h3F) ? 8'hAF : {2'b10, addr_q[5:0]};
    assign is_tx_c   = (state_q == S_TXCMD) || (state_q == S_DATA) || (state_q == S_EXT);
`else
    logic addr_hi_unused;
    assign addr_hi_unused = ^{bus.addr[7:6], addr_q[7:6]};
    assign cmd_new_c = {2'b10, bus.addr[5:0]};
    assign cmd_lat_c = {2'b10, addr_q[5:0]};
    assign is_tx_c   = (state_q == S_TXCMD) || (state_q == S_DATA);
`endif

    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Link drives the bus only while the PHY has handed it over
    assign ulpi_data = (oe_q && !bus.ulpi_dir) ? data_q : 8'hzz;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.ulpi_stp = stp_q;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            data_q  <= 8'h00;
            oe_q    <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            stp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            stp_q   <= stp_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        oe_d    = oe_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        stp_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.en && !bus.ulpi_dir) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    busy_d  = 1'b1;
                    data_d  = cmd_new_c;
                    cnt_d   = '0;
                    state_d = S_TXCMD;
                end
            end
            S_STP: begin
                // dir rising here is ignored: the write already completed
                busy_d  = 1'b0;
                data_d  = 8'h00;
                state_d = S_IDLE;
            end
            S_WAIT: begin
                cnt_d = '0;
                if (!bus.ulpi_dir) begin
                    oe_d    = 1'b1;
                    data_d  = cmd_lat_c;
                    state_d = S_TXCMD;
                end
            end
            default: begin
                if (!is_tx_c) begin
                    state_d = S_IDLE;
                end else if (bus.ulpi_dir) begin
                    // PHY took the bus: release it and retry the whole command later
                    oe_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else if (bus.ulpi_nxt) begin
                    cnt_d = '0;
                    if (state_q == S_TXCMD) begin
`ifdef ULPI_EXT_ADDR_EN
                        if (addr_q > 8'h3F) begin
                            data_d  = addr_q;
                            state_d = S_EXT;
                        end else begin
                            data_d  = wdata_q;
                            state_d = S_DATA;
                        end
`else
                        data_d  = wdata_q;
                        state_d = S_DATA;
`endif
                    end else if (state_q == S_DATA) begin
                        data_d  = 8'h00;
                        stp_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_STP;
                    end else begin
                        data_d  = wdata_q;
                        state_d = S_DATA;
                    end
                end else if (cnt_inc_c == TO_LIMIT) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    data_d  = 8'h00;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_ulpi_reg_write.sv
// tb_ulpi_reg_write: directed scenarios plus randomized PHY/request traffic, checked each
// cycle against a byte-list reference model of the register-write transaction.
module tb_ulpi_reg_write;
    localparam int unsigned TO = 8;

    logic       clk;
    logic       rst;
    logic [7:0] phy_val;
    wire  [7:0] ulpi_data;

    ulpi_reg_write_if bus_if ();

    // PHY drives the data bus whenever it owns it
    assign ulpi_data = bus_if.ulpi_dir ? phy_val : 8'hzz;

    ulpi_reg_write #(.NXT_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .ulpi_data (ulpi_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    // Reference model: the write is the byte list m_bytes; m_idx is the byte on the bus
    logic [7:0] m_bytes [3];
    int         m_nbytes;
    int         m_idx;
    int         m_stall;
    bit         m_active;
    bit         m_released;
    bit         m_in_stp;
    logic [7:0] m_drive;
    bit         e_busy, e_done, e_err, e_stp;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_bytes(input logic [7:0] a, input logic [7:0] wd);
`ifdef ULPI_EXT_ADDR_EN
        if (a > 8'h3F) begin
            m_bytes[0] = 8'hAF;
            m_bytes[1] = a;
            m_bytes[2] = wd;
            m_nbytes   = 3;
        end else begin
            m_bytes[0] = 8'h80 | (a & 8'h3F);
            m_bytes[1] = wd;
            m_nbytes   = 2;
        end
`else
        m_bytes[0] = 8'h80 | (a & 8'h3F);
        m_bytes[1] = wd;
        m_nbytes   = 2;
`endif
    endtask

    task automatic model_step();
        e_done = 0;
        e_err  = 0;
        e_stp  = 0;
        if (rst) begin
            m_active = 0; m_released = 0; m_in_stp = 0; m_stall = 0; m_drive = 8'h00;
        end else if (m_in_stp) begin
            m_in_stp = 0;
            m_active = 0;
        end else if (!m_active) begin
            if (bus_if.en && !bus_if.ulpi_dir) begin
                build_bytes(bus_if.addr, bus_if.wdata);
                m_idx = 0; m_active = 1; m_released = 0; m_stall = 0;
                m_drive = m_bytes[0];
            end
        end else if (m_released) begin
            if (!bus_if.ulpi_dir) begin
                m_released = 0; m_idx = 0; m_stall = 0;
                m_drive = m_bytes[0];
            end
        end else if (bus_if.ulpi_dir) begin
            m_released = 1;
            m_stall    = 0;
        end else if (bus_if.ulpi_nxt) begin
            m_idx++;
            m_stall = 0;
            if (m_idx == m_nbytes) begin
                m_in_stp = 1; e_stp = 1; e_done = 1; m_drive = 8'h00;
            end else begin
                m_drive = m_bytes[m_idx];
            end
        end else begin
            m_stall++;
            if (m_stall == int'(TO)) begin
                m_active = 0; e_err = 1; m_drive = 8'h00; m_stall = 0;
            end
        end
        e_busy = m_active;
    endtask

    task automatic compare_outputs();
        check_eq("busy",  16'(bus_if.busy),     16'(e_busy));
        check_eq("done",  16'(bus_if.done),     16'(e_done));
        check_eq("error", 16'(bus_if.error),    16'(e_err));
        check_eq("stp",   16'(bus_if.ulpi_stp), 16'(e_stp));
        if (bus_if.ulpi_dir)
            check_eq("bus_phy", 16'(ulpi_data), 16'(phy_val));
        else if (!m_released)
            check_eq("bus_link", 16'(ulpi_data), 16'(m_drive));
        if (bus_if.done) done_seen++;
    endtask

    // One clock: apply inputs, let the edge happen, update model, check at negedge
    task automatic cyc(input logic en, input logic dir, input logic nxt, input logic rst_v);
        bus_if.en       = en;
        bus_if.ulpi_dir = dir;
        bus_if.ulpi_nxt = nxt;
        rst             = rst_v;
        phy_val         = 8'($urandom);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        int base;
        int nxt_pct;
        int dir_left;
        bus_if.addr = 8'h0A;
        bus_if.wdata = 8'h45;
        m_active = 0; m_released = 0; m_in_stp = 0; m_stall = 0; m_drive = 8'h00;
        m_idx = 0; m_nbytes = 2;

        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check_eq("rst_busy", 16'(bus_if.busy), 16'h0);
        check_eq("rst_bus",  16'(ulpi_data),   16'h00);
        cyc(0, 0, 0, 0);

        // Basic write, NXT immediately: 8A, 45, stp/done
        cyc(1, 0, 0, 0);
        check_eq("t1_txcmd", 16'(ulpi_data), 16'h8A);
        cyc(0, 0, 1, 0);
        check_eq("t1_data", 16'(ulpi_data), 16'h45);
        cyc(0, 0, 1, 0);
        check_eq("t1_stpbus", 16'(ulpi_data), 16'h00);
        check_eq("t1_done", 16'({bus_if.ulpi_stp, bus_if.done}), 16'h3);
        cyc(0, 0, 0, 0);
        check_eq("t1_busy_low", 16'(bus_if.busy), 16'h0);

        // NXT stalled three cycles in TXCMD
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            check_eq("t2_hold", 16'(ulpi_data), 16'h8A);
        end
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check_eq("t2_done", 16'(bus_if.done), 16'h1);
        cyc(0, 0, 0, 0);

        // PHY takes bus for 5 cycles during DATA, then retry
        base = done_seen;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check_eq("t3_retx", 16'(ulpi_data), 16'h8A);
        cyc(0, 0, 1, 0);
        check_eq("t3_data", 16'(ulpi_data), 16'h45);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check_eq("t3_done_once", 16'(done_seen - base), 16'h1);

        // NXT never asserted: timeout after TO stalled cycles
        cyc(1, 0, 0, 0);
        for (int i = 1; i < int'(TO); i++) cyc(0, 0, 0, 0);
        check_eq("t4_no_err_yet", 16'(bus_if.error), 16'h0);
        cyc(0, 0, 0, 0);
        check_eq("t4_err", 16'({bus_if.error, bus_if.busy, bus_if.ulpi_stp}), 16'h4);
        check_eq("t4_bus", 16'(ulpi_data), 16'h00);
        cyc(0, 0, 0, 0);

        // Reset in DATA, then a fresh request
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        check_eq("t5_rst", 16'({bus_if.busy, bus_if.done, bus_if.ulpi_stp}), 16'h0);
        check_eq("t5_bus", 16'(ulpi_data), 16'h00);
        cyc(1, 0, 0, 0);
        check_eq("t5_reaccept", 16'({bus_if.busy, ulpi_data}), 16'h18A);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Address above 8'h3F
        bus_if.addr = 8'h81;
        bus_if.wdata = 8'h33;
        cyc(1, 0, 0, 0);
`ifdef ULPI_EXT_ADDR_EN
        check_eq("t6_cmd", 16'(ulpi_data), 16'hAF);
        cyc(0, 0, 1, 0);
        check_eq("t6_ext", 16'(ulpi_data), 16'h81);
`else
        check_eq("t6_cmd", 16'(ulpi_data), 16'h81);
`endif
        cyc(0, 0, 1, 0);
        check_eq("t6_data", 16'(ulpi_data), 16'h33);
        cyc(0, 0, 1, 0);
        check_eq("t6_stp", 16'({bus_if.ulpi_stp, ulpi_data}), 16'h100);
        cyc(0, 0, 0, 0);

        // Randomized traffic in phases of differing NXT density
        dir_left = 0;
        for (int i = 0; i < 4000; i++) begin
            logic en_r, dir_r, nxt_r, rst_r;
            case (i / 800)
                0: nxt_pct = 70;
                1: nxt_pct = 40;
                2: nxt_pct = 0;
                3: nxt_pct = 90;
                default: nxt_pct = 50;
            endcase
            if (dir_left > 0) begin
                dir_r = 1'b1;
                dir_left--;
            end else if ($urandom_range(99) < 4) begin
                dir_r = 1'b1;
                dir_left = int'($urandom_range(5));
            end else begin
                dir_r = 1'b0;
            end
            nxt_r = ($urandom_range(99) < 32'(nxt_pct));
            en_r  = ($urandom_range(1) == 1);
            rst_r = ($urandom_range(199) == 0);
            bus_if.addr  = ($urandom_range(1) == 1) ? 8'($urandom) : 8'($urandom_range(63));
            bus_if.wdata = 8'($urandom);
            cyc(en_r, dir_r, nxt_r, rst_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
